// File: rtl/tlb_pkg.sv
// Shared TLB-path definitions: PTE bit positions, exception causes,
// privilege encodings and the leaf-PTE checker FSM states.
package tlb_pkg;

  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_R       = 1;
  localparam int unsigned PTE_W       = 2;
  localparam int unsigned PTE_X       = 3;
  localparam int unsigned PTE_U       = 4;
  localparam int unsigned PTE_G       = 5;
  localparam int unsigned PTE_A       = 6;
  localparam int unsigned PTE_D       = 7;
  localparam int unsigned PTE_PPN_LSB = 10;

  localparam int unsigned CAUSE_W = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_IPF  = 4'd12;
  localparam logic [CAUSE_W-1:0] CAUSE_LPF  = 4'd13;
  localparam logic [CAUSE_W-1:0] CAUSE_SPF  = 4'd15;
  localparam logic [CAUSE_W-1:0] CAUSE_IAF  = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_LAF  = 4'd5;
  localparam logic [CAUSE_W-1:0] CAUSE_SAF  = 4'd7;

  localparam int unsigned PRIV_W = 4;

  localparam logic [PRIV_W-1:0] PRIV_U = 4'b0001;
  localparam logic [PRIV_W-1:0] PRIV_S = 4'b0010;
  localparam logic [PRIV_W-1:0] PRIV_M = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WB,
    ST_RSP
  } state_t;

endpackage

// File: rtl/pte_perm_comb.sv
// Combinational leaf-PTE check: encoding, superpage alignment, privilege,
// access type and A/D state, plus the page/access fault cause for the access.
module pte_perm_comb
  import tlb_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned LEVELS       = 3,
  parameter int unsigned HW_AD_UPDATE = 1,
  localparam int unsigned LW          = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic [XLEN-1:0]    pte,
  input  logic [LW-1:0]      level,
  input  logic [PRIV_W-1:0]  priv,
  input  logic               mxr,
  input  logic               sum,
  input  logic               rd,
  input  logic               wr,
  input  logic               ex,
  output logic               fault_c,
  output logic               ad_needed_c,
  output logic [CAUSE_W-1:0] pf_cause_c,
  output logic [CAUSE_W-1:0] af_cause_c
);

  localparam int unsigned VPN_W = (XLEN == 32) ? 10 : 9;
  localparam int unsigned PPN_W = XLEN - PTE_PPN_LSB;
  localparam logic        HW_AD = (HW_AD_UPDATE != 0);

  logic v, r, w, x, u, a, d;
  logic enc_bad, misaligned, priv_bad, access_bad, ad_missing, base_fault;
  logic [PPN_W-1:0] ppn, align_mask;
  logic [31:0]      align_bits;
  logic             unused_pte_bits;

  assign v = pte[PTE_V];
  assign r = pte[PTE_R];
  assign w = pte[PTE_W];
  assign x = pte[PTE_X];
  assign u = pte[PTE_U];
  assign a = pte[PTE_A];
  assign d = pte[PTE_D];

  // G and the software RSW bits play no part in the permission decision
  assign unused_pte_bits = ^{pte[PTE_G], pte[9:8]};

  // Invalid, reserved R=0/W=1, or a pointer PTE that should not reach a leaf check
  assign enc_bad = !v || (!r && w) || (!r && !x);

  // A level-L superpage must have the low L VPN-slices of its PPN clear
  assign ppn        = pte[XLEN-1:PTE_PPN_LSB];
  assign align_bits = VPN_W * 32'(level);
  assign align_mask = ~({PPN_W{1'b1}} << align_bits);
  assign misaligned = |(ppn & align_mask);

  always_comb begin
    priv_bad = 1'b1;
    case (priv)
      PRIV_U:  priv_bad = !u;
      PRIV_S:  priv_bad = u && (!sum || ex);
      PRIV_M:  priv_bad = 1'b0;
      default: priv_bad = 1'b1;
    endcase
  end

  assign access_bad = (rd && !(r || (x && mxr))) || (wr && !w) || (ex && !x)
                   || !(rd || wr || ex);

  assign ad_missing = !a || (wr && !d);
  assign base_fault = enc_bad || misaligned || priv_bad || access_bad;

  assign fault_c     = base_fault || (ad_missing && !HW_AD);
  assign ad_needed_c = !base_fault && ad_missing && HW_AD;

  always_comb begin
    pf_cause_c = CAUSE_LPF;
    af_cause_c = CAUSE_LAF;
    if (ex) begin
      pf_cause_c = CAUSE_IPF;
      af_cause_c = CAUSE_IAF;
    end else if (wr) begin
      pf_cause_c = CAUSE_SPF;
      af_cause_c = CAUSE_SAF;
    end
  end

endmodule

// File: rtl/pte_perm_check.sv
// Leaf-PTE permission checker between the page-table walker and TLB refill:
// latches one request, checks it, optionally writes back A/D, then responds.
module pte_perm_check
  import tlb_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned LEVELS       = 3,
  parameter int unsigned HW_AD_UPDATE = 1,
  localparam int unsigned LW          = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRIV_W-1:0]  priv,
  input  logic               mxr,
  input  logic               sum,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_read,
  input  logic               req_write,
  input  logic               req_execute,
  input  logic [XLEN-1:0]    req_pte,
  input  logic [XLEN-1:0]    req_pte_addr,
  input  logic [LW-1:0]      req_level,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_ok,
  output logic [CAUSE_W-1:0] rsp_cause,
  output logic [XLEN-1:0]    rsp_pte,
  output logic               wb_valid,
  input  logic               wb_ready,
  input  logic               wb_err,
  output logic [XLEN-1:0]    wb_addr,
  output logic [XLEN-1:0]    wb_data
);

  state_t state, state_nx;

  logic [XLEN-1:0]   pte_q, addr_q, ad_pte;
  logic [LW-1:0]     level_q;
  logic [PRIV_W-1:0] priv_q;
  logic              mxr_q, sum_q, rd_q, wr_q, ex_q;
  logic              latch_en;

  logic               req_ready_nx, rsp_valid_nx, rsp_ok_nx, wb_valid_nx;
  logic [CAUSE_W-1:0] rsp_cause_nx;
  logic [XLEN-1:0]    rsp_pte_nx, wb_addr_nx, wb_data_nx;

  logic               fault_c, ad_needed_c;
  logic [CAUSE_W-1:0] pf_cause_c, af_cause_c;

  pte_perm_comb #(
    .XLEN         (XLEN),
    .LEVELS       (LEVELS),
    .HW_AD_UPDATE (HW_AD_UPDATE)
  ) u_comb (
    .pte         (pte_q),
    .level       (level_q),
    .priv        (priv_q),
    .mxr         (mxr_q),
    .sum         (sum_q),
    .rd          (rd_q),
    .wr          (wr_q),
    .ex          (ex_q),
    .fault_c     (fault_c),
    .ad_needed_c (ad_needed_c),
    .pf_cause_c  (pf_cause_c),
    .af_cause_c  (af_cause_c)
  );

  // Value written back to memory: A always set, D set for writes
  always_comb begin
    ad_pte        = pte_q;
    ad_pte[PTE_A] = 1'b1;
    ad_pte[PTE_D] = pte_q[PTE_D] | wr_q;
  end

  // Request latch; mode bits are captured here so later changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pte_q   <= '0;
      addr_q  <= '0;
      level_q <= '0;
      priv_q  <= '0;
      mxr_q   <= 1'b0;
      sum_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ex_q    <= 1'b0;
    end else if (latch_en) begin
      pte_q   <= req_pte;
      addr_q  <= req_pte_addr;
      level_q <= req_level;
      priv_q  <= priv;
      mxr_q   <= mxr;
      sum_q   <= sum;
      rd_q    <= req_read;
      wr_q    <= req_write;
      ex_q    <= req_execute;
    end
  end

  // Next state and next registered-output values
  always_comb begin
    state_nx     = state;
    latch_en     = 1'b0;
    req_ready_nx = req_ready;
    rsp_valid_nx = rsp_valid;
    rsp_ok_nx    = rsp_ok;
    rsp_cause_nx = rsp_cause;
    rsp_pte_nx   = rsp_pte;
    wb_valid_nx  = wb_valid;
    wb_addr_nx   = wb_addr;
    wb_data_nx   = wb_data;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          latch_en     = 1'b1;
          state_nx     = ST_CHECK;
          req_ready_nx = 1'b0;
        end
      end

      ST_CHECK: begin
        if (fault_c) begin
          state_nx     = ST_RSP;
          rsp_valid_nx = 1'b1;
          rsp_ok_nx    = 1'b0;
          rsp_cause_nx = pf_cause_c;
          rsp_pte_nx   = pte_q;
        end else if (ad_needed_c) begin
          state_nx    = ST_WB;
          wb_valid_nx = 1'b1;
          wb_addr_nx  = addr_q;
          wb_data_nx  = ad_pte;
        end else begin
          state_nx     = ST_RSP;
          rsp_valid_nx = 1'b1;
          rsp_ok_nx    = 1'b1;
          rsp_cause_nx = CAUSE_NONE;
          rsp_pte_nx   = pte_q;
        end
      end

      ST_WB: begin
        if (wb_ready) begin
          state_nx     = ST_RSP;
          wb_valid_nx  = 1'b0;
          rsp_valid_nx = 1'b1;
          if (wb_err) begin
            rsp_ok_nx    = 1'b0;
            rsp_cause_nx = af_cause_c;
            rsp_pte_nx   = pte_q;
          end else begin
            rsp_ok_nx    = 1'b1;
            rsp_cause_nx = CAUSE_NONE;
            rsp_pte_nx   = wb_data;
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_nx     = ST_IDLE;
          rsp_valid_nx = 1'b0;
          req_ready_nx = 1'b1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_cause <= '0;
      rsp_pte   <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_ok    <= rsp_ok_nx;
      rsp_cause <= rsp_cause_nx;
      rsp_pte   <= rsp_pte_nx;
      wb_valid  <= wb_valid_nx;
      wb_addr   <= wb_addr_nx;
      wb_data   <= wb_data_nx;
    end
  end

endmodule

// File: tb/tb_pte_perm_check.sv
// Directed bench for pte_perm_check: one DUT with hardware A/D update and
// one without, exercising checks, writeback handshake, reset and throughput.
module tb_pte_perm_check;

  localparam logic [3:0] PU = 4'b0001;
  localparam logic [3:0] PS = 4'b0010;
  localparam logic [3:0] PM = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  priv;
  logic        mxr, sum;
  logic        req_valid, nad_req_valid;
  logic        req_read, req_write, req_execute;
  logic [63:0] req_pte, req_pte_addr;
  logic [1:0]  req_level;
  logic        rsp_ready, wb_ready, wb_err;

  logic        req_ready, rsp_valid, rsp_ok, wb_valid;
  logic [3:0]  rsp_cause;
  logic [63:0] rsp_pte, wb_addr, wb_data;

  logic        nad_req_ready, nad_rsp_valid, nad_rsp_ok, nad_wb_valid;
  logic [3:0]  nad_rsp_cause;
  logic [63:0] nad_rsp_pte, nad_wb_addr, nad_wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pte_perm_check #(.XLEN(64), .LEVELS(3), .HW_AD_UPDATE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .priv(priv), .mxr(mxr), .sum(sum),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_execute(req_execute),
    .req_pte(req_pte), .req_pte_addr(req_pte_addr), .req_level(req_level),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
    .rsp_cause(rsp_cause), .rsp_pte(rsp_pte),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_err(wb_err),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  pte_perm_check #(.XLEN(64), .LEVELS(3), .HW_AD_UPDATE(0)) u_dut_nad (
    .clk(clk), .rst_n(rst_n), .priv(priv), .mxr(mxr), .sum(sum),
    .req_valid(nad_req_valid), .req_ready(nad_req_ready),
    .req_read(req_read), .req_write(req_write), .req_execute(req_execute),
    .req_pte(req_pte), .req_pte_addr(req_pte_addr), .req_level(req_level),
    .rsp_valid(nad_rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(nad_rsp_ok),
    .rsp_cause(nad_rsp_cause), .rsp_pte(nad_rsp_pte),
    .wb_valid(nad_wb_valid), .wb_ready(wb_ready), .wb_err(wb_err),
    .wb_addr(nad_wb_addr), .wb_data(nad_wb_data)
  );

  // Present one request for a single accepting edge; returns in the CHECK cycle
  task automatic send(input logic [3:0] p, input logic m, input logic s,
                      input logic r, input logic w, input logic x,
                      input logic [63:0] pte, input logic [63:0] addr,
                      input logic [1:0] lvl, input bit to_nad);
    priv = p; mxr = m; sum = s;
    req_read = r; req_write = w; req_execute = x;
    req_pte = pte; req_pte_addr = addr; req_level = lvl;
    if (to_nad) nad_req_valid = 1'b1;
    else        req_valid     = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nad_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte, wb_addr, wb_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b ok=%b wb=%b c=%0d pte=%h wa=%h wd=%h want all 0",
               rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte, wb_addr, wb_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || nad_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_req_ready: got %b/%b want 1/1", req_ready, nad_req_ready);
    end
  endtask

  task automatic test_user_read();
    send(PU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDF, 64'h1000, 2'd0, 1'b0);
    total++;
    if (rsp_valid !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ur_check_cycle: got rv=%b wv=%b rr=%b want 0/0/0", rsp_valid, wb_valid, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, rsp_ok, rsp_cause, wb_valid} !== {1'b1, 1'b1, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL ur_result: got v=%b ok=%b c=%0d wb=%b want v=1 ok=1 c=0 wb=0",
               rsp_valid, rsp_ok, rsp_cause, wb_valid);
    end
    total++;
    if (rsp_pte !== 64'hDF) begin
      bad++;
      $display("FAIL ur_pte: got %h want df", rsp_pte);
    end
    // Response is held under back-pressure
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_pte !== 64'hDF || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL ur_hold: got v=%b pte=%h rr=%b want 1/df/0", rsp_valid, rsp_pte, req_ready);
    end
    finish_rsp();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ur_release: got v=%b rr=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sum_exec();
    int n;
    send(PS, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hDB, 64'h2000, 2'd0, 1'b0);
    wait_rsp(n);
    total++;
    if (n != 1 || rsp_ok !== 1'b0 || rsp_cause !== 4'd12) begin
      bad++;
      $display("FAIL s_exec_upage: got n=%0d ok=%b c=%0d want n=1 ok=0 c=12", n, rsp_ok, rsp_cause);
    end
    finish_rsp();
    // Mode bits change right after accept; the latched values must be used
    send(PS, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hDB, 64'h2000, 2'd0, 1'b0);
    priv = 4'b0100; sum = 1'b0;
    wait_rsp(n);
    total++;
    if (rsp_ok !== 1'b1 || rsp_cause !== 4'd0) begin
      bad++;
      $display("FAIL s_read_sum1: got ok=%b c=%0d want ok=1 c=0", rsp_ok, rsp_cause);
    end
    finish_rsp();
    send(PS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDB, 64'h2000, 2'd0, 1'b0);
    wait_rsp(n);
    total++;
    if (rsp_ok !== 1'b0 || rsp_cause !== 4'd13) begin
      bad++;
      $display("FAIL s_read_sum0: got ok=%b c=%0d want ok=0 c=13", rsp_ok, rsp_cause);
    end
    finish_rsp();
    // Execute-only page readable with mxr
    send(PS, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'hC9, 64'h2000, 2'd0, 1'b0);
    wait_rsp(n);
    total++;
    if (rsp_ok !== 1'b1 || rsp_cause !== 4'd0) begin
      bad++;
      $display("FAIL s_read_mxr: got ok=%b c=%0d want ok=1 c=0", rsp_ok, rsp_cause);
    end
    finish_rsp();
  endtask

  task automatic test_ad_writeback();
    logic [63:0] addr = 64'h0000_0000_8000_1238;
    send(PS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h47, addr, 2'd0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 64'hC7 || wb_addr !== addr || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL wb_issue: got wv=%b wd=%h wa=%h rv=%b want 1/c7/%h/0",
               wb_valid, wb_data, wb_addr, rsp_valid, addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (wb_valid !== 1'b1 || wb_data !== 64'hC7 || wb_addr !== addr || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL wb_hold%0d: got wv=%b wd=%h wa=%h rv=%b want 1/c7/%h/0",
                 i, wb_valid, wb_data, wb_addr, rsp_valid, addr);
      end
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    total++;
    if ({rsp_valid, rsp_ok, rsp_cause, wb_valid} !== {1'b1, 1'b1, 4'd0, 1'b0} || rsp_pte !== 64'hC7) begin
      bad++;
      $display("FAIL wb_rsp: got v=%b ok=%b c=%0d wv=%b pte=%h want 1/1/0/0/c7",
               rsp_valid, rsp_ok, rsp_cause, wb_valid, rsp_pte);
    end
    finish_rsp();
    // Without hardware A/D update the same access faults with no writeback
    send(PS, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h47, addr, 2'd0, 1'b1);
    total++;
    if (nad_wb_valid !== 1'b0 || nad_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL nad_check_cycle: got wv=%b rv=%b want 0/0", nad_wb_valid, nad_rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({nad_rsp_valid, nad_rsp_ok, nad_rsp_cause, nad_wb_valid} !== {1'b1, 1'b0, 4'd15, 1'b0}
        || nad_rsp_pte !== 64'h47) begin
      bad++;
      $display("FAIL nad_fault: got v=%b ok=%b c=%0d wv=%b pte=%h want 1/0/15/0/47",
               nad_rsp_valid, nad_rsp_ok, nad_rsp_cause, nad_wb_valid, nad_rsp_pte);
    end
    finish_rsp();
  endtask

  task automatic test_superpage();
    logic [63:0] ptes [6] = '{64'h4C3, 64'h4C3, 64'h400C3, 64'h800C3, 64'h080000C3, 64'h100000C3};
    logic [1:0]  lvls [6] = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic        oks  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 6; i++) begin
      send(PS, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ptes[i], 64'h3000, lvls[i], 1'b0);
      wait_rsp(n);
      total++;
      if (rsp_ok !== oks[i] || rsp_cause !== (oks[i] ? 4'd0 : 4'd13) || rsp_pte !== ptes[i]) begin
        bad++;
        $display("FAIL superpage%0d: got ok=%b c=%0d pte=%h want ok=%b c=%0d pte=%h",
                 i, rsp_ok, rsp_cause, rsp_pte, oks[i], oks[i] ? 4'd0 : 4'd13, ptes[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_cause_edge();
    logic [3:0]  privs [8] = '{PM, 4'b0100, 4'b0011, PM, PM, PM, PM, PU};
    logic [2:0]  acc   [8] = '{3'b000, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100, 3'b100};
    logic [63:0] ptes  [8] = '{64'hDF, 64'hDF, 64'hDF, 64'hDB, 64'hC7, 64'hC5, 64'hDE, 64'hCF};
    logic [3:0]  exp   [8] = '{4'd13, 4'd13, 4'd13, 4'd15, 4'd12, 4'd13, 4'd13, 4'd13};
    int n;
    for (int i = 0; i < 8; i++) begin
      send(privs[i], 1'b0, 1'b0, acc[i][2], acc[i][1], acc[i][0], ptes[i], 64'h6000, 2'd0, 1'b0);
      wait_rsp(n);
      total++;
      if (rsp_ok !== 1'b0 || rsp_cause !== exp[i] || wb_valid !== 1'b0) begin
        bad++;
        $display("FAIL cause%0d: got ok=%b c=%0d wv=%b want ok=0 c=%0d wv=0",
                 i, rsp_ok, rsp_cause, wb_valid, exp[i]);
      end
      finish_rsp();
    end
  endtask

  task automatic test_wb_err();
    send(PM, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h83, 64'h4008, 2'd0, 1'b0);
    wb_ready = 1'b1; wb_err = 1'b1;
    @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 64'hC3 || wb_addr !== 64'h4008) begin
      bad++;
      $display("FAIL wberr_issue: got wv=%b wd=%h wa=%h want 1/c3/4008", wb_valid, wb_data, wb_addr);
    end
    @(posedge clk); #1;
    wb_ready = 1'b0; wb_err = 1'b0;
    total++;
    if ({rsp_valid, rsp_ok, rsp_cause, wb_valid} !== {1'b1, 1'b0, 4'd5, 1'b0} || rsp_pte !== 64'h83) begin
      bad++;
      $display("FAIL wberr_rsp: got v=%b ok=%b c=%0d wv=%b pte=%h want 1/0/5/0/83",
               rsp_valid, rsp_ok, rsp_cause, wb_valid, rsp_pte);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    int n;
    send(PM, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h07, 64'h5000, 2'd0, 1'b0);
    @(posedge clk); #1;
    total++;
    if (wb_valid !== 1'b1 || wb_data !== 64'hC7) begin
      bad++;
      $display("FAIL rstwb_pre: got wv=%b wd=%h want 1/c7", wb_valid, wb_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte, wb_addr, wb_data} !== '0) begin
      bad++;
      $display("FAIL rstwb_zero: got v=%b ok=%b wv=%b c=%0d pte=%h wa=%h wd=%h want all 0",
               rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte, wb_addr, wb_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstwb_release: got rr=%b wv=%b want 1/0", req_ready, wb_valid);
    end
    send(PU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDF, 64'h1000, 2'd0, 1'b0);
    wait_rsp(n);
    total++;
    if (n != 1 || rsp_ok !== 1'b1 || rsp_pte !== 64'hDF) begin
      bad++;
      $display("FAIL rstwb_next: got n=%0d ok=%b pte=%h want 1/1/df", n, rsp_ok, rsp_pte);
    end
    // Second reset while stalled in RSP
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte, wb_addr, wb_data} !== '0) begin
      bad++;
      $display("FAIL rstrsp_zero: got v=%b ok=%b wv=%b c=%0d pte=%h want all 0",
               rsp_valid, rsp_ok, wb_valid, rsp_cause, rsp_pte);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstrsp_release: got rr=%b v=%b want 1/0", req_ready, rsp_valid);
    end
    send(PS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hCF, 64'h1000, 2'd0, 1'b0);
    wait_rsp(n);
    total++;
    if (n != 1 || rsp_ok !== 1'b1 || rsp_cause !== 4'd0) begin
      bad++;
      $display("FAIL rstrsp_next: got n=%0d ok=%b c=%0d want 1/1/0", n, rsp_ok, rsp_cause);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsps = 0;
    priv = PU; mxr = 1'b0; sum = 1'b0;
    req_read = 1'b1; req_write = 1'b0; req_execute = 1'b0;
    req_pte = 64'hDF; req_pte_addr = 64'h7000; req_level = 2'd0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready === 1'b1) acc++;
      if (rsp_valid === 1'b1) rsps++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    total++;
    if (acc != 3 || rsps != 3) begin
      bad++;
      $display("FAIL b2b_throughput: got accepts=%0d rsps=%0d want 3/3", acc, rsps);
    end
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got rr=%b v=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  initial begin
    priv = PM; mxr = 1'b0; sum = 1'b0;
    req_valid = 1'b0; nad_req_valid = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_execute = 1'b0;
    req_pte = '0; req_pte_addr = '0; req_level = '0;
    rsp_ready = 1'b0; wb_ready = 1'b0; wb_err = 1'b0;
    test_reset();
    test_user_read();
    test_sum_exec();
    test_ad_writeback();
    test_superpage();
    test_cause_edge();
    test_wb_err();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
